// File: rtl/demo_sequencer.sv
// demo_sequencer: frame-synchronous scene scheduler.
// Counts frames from the falling edge of v_sync, steps through NUM_SCENES
// scenes and produces a beat pulse every FRAMES_PER_BEAT frames.
// Define DEMO_SEQ_FADE_EN to enable the FADE_IN / RUN / FADE_OUT brightness
// fades between scenes; without it the sequencer cuts straight between
// scenes and fade stays at full brightness.

module demo_sequencer #(
    parameter int NUM_SCENES      = 4,
    parameter int SCENE_FRAMES    = 240,
    parameter int FADE_FRAMES     = 4,
    parameter int FRAMES_PER_BEAT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       v_sync,
    input  logic       hold,
    input  logic       skip,
    output logic [2:0] scene,
    output logic [7:0] scene_frame,
    output logic [1:0] fade,
    output logic       new_scene,
    output logic       beat,
    output logic [3:0] beat_step
);

    // A configuration outside the supported ranges would truncate the
    // counters below, so such a build never generates frame ticks.
    localparam bit CFG_OK = (NUM_SCENES >= 1) && (NUM_SCENES <= 8) &&
                            (SCENE_FRAMES >= 2) && (SCENE_FRAMES <= 255) &&
                            (FADE_FRAMES >= 1) && (FADE_FRAMES <= 255) &&
                            (FRAMES_PER_BEAT >= 1) && (FRAMES_PER_BEAT <= 255);

    localparam logic [2:0] SCENE_LAST = 3'(NUM_SCENES - 1);
    localparam logic [7:0] FRAME_LAST = 8'(SCENE_FRAMES - 1);
    localparam logic [7:0] BEAT_LAST  = 8'(FRAMES_PER_BEAT - 1);

    // Input edge detection
    logic       vs_q, vs_d;
    logic       skip_q, skip_d;
    logic       tick;
    logic       step_en;
    logic       skip_rise;

    // Beat divider
    logic [7:0] bdiv_q, bdiv_d;
    logic       beat_q, beat_d;
    logic [3:0] beat_step_q, beat_step_d;

    // Scene state shared by both builds
    logic [2:0] scene_q, scene_d;
    logic [7:0] scene_frame_q, scene_frame_d;
    logic       new_scene_q, new_scene_d;
    logic       skip_pend_q, skip_pend_d;

    // Helpers derived from the current scene state
    logic [7:0] frame_inc;
    logic [2:0] scene_next;

    assign tick      = CFG_OK & vs_q & ~v_sync;
    assign step_en   = tick & ~hold;
    assign skip_rise = skip & ~skip_q;

    assign frame_inc  = (scene_frame_q == 8'hFF) ? 8'hFF : scene_frame_q + 8'd1;
    assign scene_next = (scene_q == SCENE_LAST) ? 3'd0 : scene_q + 3'd1;

    // Next values of the edge-detect samplers
    always_comb begin
        vs_d   = v_sync;
        skip_d = skip;
    end

    // Beat divider runs on every tick regardless of hold or scene state
    always_comb begin
        bdiv_d      = bdiv_q;
        beat_d      = 1'b0;
        beat_step_d = beat_step_q;
        if (tick) begin
            if (bdiv_q == BEAT_LAST) begin
                bdiv_d      = 8'd0;
                beat_d      = 1'b1;
                beat_step_d = beat_step_q + 4'd1;
            end else begin
                bdiv_d = bdiv_q + 8'd1;
            end
        end
    end

`ifdef DEMO_SEQ_FADE_EN

    localparam logic [7:0] FADE_LAST = 8'(FADE_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_FADE_IN  = 2'd0,
        ST_RUN      = 2'd1,
        ST_FADE_OUT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic [1:0] fade_q, fade_d;

    // Scene FSM: fade in, hold at full brightness, fade out, next scene
    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        fade_d        = fade_q;
        scene_d       = scene_q;
        scene_frame_d = scene_frame_q;
        new_scene_d   = 1'b0;
        skip_pend_d   = skip_pend_q;

        if ((state_q == ST_RUN) && skip_rise) begin
            skip_pend_d = 1'b1;
        end

        if (step_en) begin
            scene_frame_d = frame_inc;
            case (state_q)
                ST_FADE_IN: begin
                    if (fcnt_q == FADE_LAST) begin
                        fcnt_d = 8'd0;
                        fade_d = fade_q + 2'd1;
                        if (fade_q == 2'd2) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        fcnt_d = fcnt_q + 8'd1;
                    end
                end
                ST_RUN: begin
                    if ((scene_frame_q == FRAME_LAST) || skip_pend_q) begin
                        state_d     = ST_FADE_OUT;
                        fcnt_d      = 8'd0;
                        skip_pend_d = 1'b0;
                    end
                end
                ST_FADE_OUT: begin
                    if (fcnt_q == FADE_LAST) begin
                        fcnt_d = 8'd0;
                        fade_d = fade_q - 2'd1;
                        if (fade_q == 2'd1) begin
                            state_d       = ST_FADE_IN;
                            scene_d       = scene_next;
                            scene_frame_d = 8'd0;
                            new_scene_d   = 1'b1;
                        end
                    end else begin
                        fcnt_d = fcnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_FADE_IN;
                    fcnt_d  = 8'd0;
                    fade_d  = 2'd0;
                end
            endcase
        end
    end

    // Fade state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FADE_IN;
            fcnt_q  <= 8'd0;
            fade_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            fade_q  <= fade_d;
        end
    end

    assign fade = fade_q;

`else

    // Hard cuts: the scene changes on the tick that ends it
    always_comb begin
        scene_d       = scene_q;
        scene_frame_d = scene_frame_q;
        new_scene_d   = 1'b0;
        skip_pend_d   = skip_pend_q;

        if (skip_rise) begin
            skip_pend_d = 1'b1;
        end

        if (step_en) begin
            if ((scene_frame_q == FRAME_LAST) || skip_pend_q) begin
                scene_d       = scene_next;
                scene_frame_d = 8'd0;
                new_scene_d   = 1'b1;
                skip_pend_d   = 1'b0;
            end else begin
                scene_frame_d = frame_inc;
            end
        end
    end

    assign fade = 2'd3;

`endif

    // Registers common to both builds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_q          <= 1'b0;
            skip_q        <= 1'b0;
            bdiv_q        <= 8'd0;
            beat_q        <= 1'b0;
            beat_step_q   <= 4'd0;
            scene_q       <= 3'd0;
            scene_frame_q <= 8'd0;
            new_scene_q   <= 1'b0;
            skip_pend_q   <= 1'b0;
        end else begin
            vs_q          <= vs_d;
            skip_q        <= skip_d;
            bdiv_q        <= bdiv_d;
            beat_q        <= beat_d;
            beat_step_q   <= beat_step_d;
            scene_q       <= scene_d;
            scene_frame_q <= scene_frame_d;
            new_scene_q   <= new_scene_d;
            skip_pend_q   <= skip_pend_d;
        end
    end

    assign scene       = scene_q;
    assign scene_frame = scene_frame_q;
    assign new_scene   = new_scene_q;
    assign beat        = beat_q;
    assign beat_step   = beat_step_q;

endmodule

// File: tb/tb_demo_sequencer.sv
// tb_demo_sequencer: scoreboard bench for demo_sequencer.
// Stimulus drives one clock cycle at a time and pushes the reference model's
// expected outputs; the monitor pops and compares on the opposite clock edge.

module tb_demo_sequencer;

    localparam int SF  = 240;
    localparam int FF  = 4;
    localparam int FPB = 15;
`ifdef DEMO_SEQ_FADE_EN
    localparam bit FADE_MODE = 1'b1;
    localparam int N_SC      = 4;
`else
    localparam bit FADE_MODE = 1'b0;
    localparam int N_SC      = 2;
`endif

    localparam int PH_IN  = 0;
    localparam int PH_RUN = 1;
    localparam int PH_OUT = 2;

    localparam logic [3:0] T_RESET  = 4'd0;
    localparam logic [3:0] T_BASE   = 4'd1;
    localparam logic [3:0] T_SKIP   = 4'd2;
    localparam logic [3:0] T_HOLD   = 4'd3;
    localparam logic [3:0] T_RAND   = 4'd4;
    localparam logic [3:0] T_MIDRST = 4'd5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v_sync;
    logic       hold;
    logic       skip;
    logic [2:0] scene;
    logic [7:0] scene_frame;
    logic [1:0] fade;
    logic       new_scene;
    logic       beat;
    logic [3:0] beat_step;

    typedef struct packed {
        logic [2:0] scene;
        logic [7:0] frame;
        logic [1:0] fade;
        logic [3:0] step;
        logic       ns;
        logic       bt;
        logic [3:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: scene bookkeeping in plain integers
    int m_scene, m_sf, m_phase, m_pticks, m_ticks;
    bit m_pend, m_vs_prev, m_skip_prev;

    bit hold_lvl;
    bit skip_lvl;

    demo_sequencer #(
        .NUM_SCENES     (N_SC),
        .SCENE_FRAMES   (SF),
        .FADE_FRAMES    (FF),
        .FRAMES_PER_BEAT(FPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .v_sync     (v_sync),
        .hold       (hold),
        .skip       (skip),
        .scene      (scene),
        .scene_frame(scene_frame),
        .fade       (fade),
        .new_scene  (new_scene),
        .beat       (beat),
        .beat_step  (beat_step)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic string tagName(input logic [3:0] t);
        case (t)
            T_RESET:  return "reset";
            T_BASE:   return "base";
            T_SKIP:   return "skip";
            T_HOLD:   return "hold";
            T_RAND:   return "random";
            default:  return "midreset";
        endcase
    endfunction

    // Brightness follows from how long the current fade phase has lasted
    function automatic logic [1:0] modelFade();
        if (m_phase == PH_IN)  return 2'(m_pticks / FF);
        if (m_phase == PH_OUT) return 2'(3 - (m_pticks / FF));
        return 2'd3;
    endfunction

    function automatic void enterNextScene(ref exp_t e);
        m_scene = (m_scene + 1) % N_SC;
        m_sf    = 0;
        e.ns    = 1'b1;
    endfunction

    task automatic modelStep(input logic vs, input logic hd, input logic sk,
                             input logic rn, output exp_t e);
        bit tick_m;
        bit rise_m;
        e = '0;
        if (!rn) begin
            m_scene     = 0;
            m_sf        = 0;
            m_phase     = FADE_MODE ? PH_IN : PH_RUN;
            m_pticks    = 0;
            m_ticks     = 0;
            m_pend      = 0;
            m_vs_prev   = 0;
            m_skip_prev = 0;
        end else begin
            tick_m      = m_vs_prev && !vs;
            rise_m      = sk && !m_skip_prev;
            m_vs_prev   = vs;
            m_skip_prev = sk;
            if (rise_m && m_phase == PH_RUN) m_pend = 1;
            if (tick_m) begin
                m_ticks++;
                if (m_ticks % FPB == 0) e.bt = 1'b1;
            end
            if (tick_m && !hd) begin
                case (m_phase)
                    PH_IN: begin
                        m_sf++;
                        m_pticks++;
                        if (m_pticks == 3 * FF) begin
                            m_phase  = PH_RUN;
                            m_pticks = 0;
                        end
                    end
                    PH_RUN: begin
                        if (m_sf == SF - 1 || m_pend) begin
                            m_pend = 0;
                            if (FADE_MODE) begin
                                m_phase  = PH_OUT;
                                m_pticks = 0;
                                m_sf++;
                            end else begin
                                enterNextScene(e);
                            end
                        end else begin
                            m_sf++;
                        end
                    end
                    default: begin
                        m_pticks++;
                        if (m_pticks == 3 * FF) begin
                            enterNextScene(e);
                            m_phase  = PH_IN;
                            m_pticks = 0;
                        end else begin
                            m_sf++;
                        end
                    end
                endcase
            end
        end
        e.scene = 3'(m_scene);
        e.frame = (m_sf > 255) ? 8'd255 : 8'(m_sf);
        e.fade  = modelFade();
        e.step  = 4'((m_ticks / FPB) % 16);
    endtask

    // Drive one clock cycle of inputs and queue the expected result
    task automatic applyStimulus(input logic vs, input logic hd, input logic sk,
                                 input logic rn, input logic [3:0] tag);
        exp_t e;
        v_sync = vs;
        hold   = hd;
        skip   = sk;
        rst_n  = rn;
        @(posedge clk);
        modelStep(vs, hd, sk, rn, e);
        e.tag = tag;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic frameTick(input logic [3:0] tag);
        int n;
        applyStimulus(1'b0, hold_lvl, skip_lvl, 1'b1, tag);
        n = int'($urandom_range(1, 3));
        repeat (n) applyStimulus(1'b1, hold_lvl, skip_lvl, 1'b1, tag);
    endtask

    task automatic pulseSkip(input logic [3:0] tag);
        skip_lvl = 1'b1;
        applyStimulus(1'b1, hold_lvl, 1'b1, 1'b1, tag);
        skip_lvl = 1'b0;
        applyStimulus(1'b1, hold_lvl, 1'b0, 1'b1, tag);
    endtask

    task automatic boundFail(input string what);
        n_checks++;
        n_errors++;
        $display("[TB] FAIL %s: wait bound expired, got no match, required condition within bound", what);
    endtask

    task automatic checkOutput(input exp_t e);
        n_checks++;
        if ({scene, scene_frame, fade, beat_step} !== {e.scene, e.frame, e.fade, e.step}) begin
            n_errors++;
            $display("[TB] FAIL %s/state @%0t: got scene=%0d frame=%0d fade=%0d step=%0d, want scene=%0d frame=%0d fade=%0d step=%0d",
                     tagName(e.tag), $time, scene, scene_frame, fade, beat_step,
                     e.scene, e.frame, e.fade, e.step);
        end
        n_checks++;
        if ({new_scene, beat} !== {e.ns, e.bt}) begin
            n_errors++;
            $display("[TB] FAIL %s/pulse @%0t: got new_scene=%0b beat=%0b, want new_scene=%0b beat=%0b",
                     tagName(e.tag), $time, new_scene, beat, e.ns, e.bt);
        end
    endtask

    // Monitor: compare whatever the stimulus queued on the opposite edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        int guard;
        hold_lvl = 1'b0;
        skip_lvl = 1'b0;
        v_sync   = 1'b0;
        hold     = 1'b0;
        skip     = 1'b0;
        rst_n    = 1'b0;

        // Reset with v_sync low, release while still low: no tick expected
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, T_RESET);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, T_RESET);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, T_RESET);

        // Fade-in, scene timeout and fade-out across several scenes
        repeat (500) frameTick(T_BASE);

        // Skip edge at scene_frame 50, then a second edge shortly after
        guard = 0;
        while (!(m_phase == PH_RUN && m_sf == 50) && guard < 600) begin
            frameTick(T_SKIP);
            guard++;
        end
        if (guard >= 600) boundFail("skip/setup");
        pulseSkip(T_SKIP);
        repeat (3) frameTick(T_SKIP);
        pulseSkip(T_SKIP);
        repeat (20) frameTick(T_SKIP);

        // Hold for 100 ticks in RUN with a skip edge latched mid-hold
        guard = 0;
        while (m_phase != PH_RUN && guard < 600) begin
            frameTick(T_HOLD);
            guard++;
        end
        if (guard >= 600) boundFail("hold/setup");
        hold_lvl = 1'b1;
        repeat (50) frameTick(T_HOLD);
        pulseSkip(T_HOLD);
        repeat (50) frameTick(T_HOLD);
        hold_lvl = 1'b0;
        repeat (20) frameTick(T_HOLD);

        // Randomised hold and skip activity
        for (int i = 0; i < 800; i++) begin
            hold_lvl = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) pulseSkip(T_RAND);
            frameTick(T_RAND);
        end
        hold_lvl = 1'b0;

        // Reset in the middle of a fade-out (or mid-scene without fades)
        guard = 0;
        while (!(FADE_MODE ? (m_phase == PH_OUT) : (m_sf > 10)) && guard < 600) begin
            frameTick(T_MIDRST);
            guard++;
        end
        if (guard >= 600) boundFail("midreset/setup");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, T_MIDRST);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, T_MIDRST);
        repeat (20) frameTick(T_MIDRST);

        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) boundFail("scoreboard/drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demo_sequencer.md
# demo_sequencer

Frame-synchronous scene scheduler for the demo top level. Counts video frames from the VGA controller's `v_sync`, steps the graphics engine through a fixed list of scenes with brightness fades between them, and emits a beat clock that paces the audio engine's pattern. It sits between `vga_controller` and the graphics/audio engines and configures which scene and brightness the graphics engine renders.

## Interface
- `NUM_SCENES`, 4: number of scenes, 1..8; scene index wraps `NUM_SCENES-1` → 0.
- `SCENE_FRAMES`, 240: frames a scene lasts before its fade-out starts, 2..255.
- `FADE_FRAMES`, 4: frames per fade level step, 1..255.
- `FRAMES_PER_BEAT`, 15: frames per beat, 1..255.

- `clk` in 1: pixel clock.
- `rst_n` in 1: synchronous, active-low reset.
- `v_sync` in 1: VGA vertical sync, active-low pulse, synchronous to `clk`.
- `hold` in 1: level; while high, scene/fade state is frozen.
- `skip` in 1: level; its rising edge requests an early scene change.
- `scene` out 3: current scene index.
- `scene_frame` out 8: frames since scene entry, saturating at 255.
- `fade` out 2: brightness level, 3 = full, 0 = black.
- `new_scene` out 1: one-cycle pulse on scene change.
- `beat` out 1: one-cycle pulse per beat.
- `beat_step` out 4: beat index mod 16.

## Operation
- Frame tick: `vs_q` register samples `v_sync`. `tick = vs_q & ~v_sync` (falling edge). `vs_q` resets to 0, so there is no tick out of reset even if `v_sync` is low.
- Beat divider, independent of `hold` and the FSM. `bdiv` counts ticks 0..FRAMES_PER_BEAT-1. On the tick where it wraps: `beat`=1 for that cycle, `beat_step` += 1 mod 16.
- Skip: `skip_q` detects rising edges. A rising edge in RUN sets `skip_pend`. Edges in fade states are ignored. `skip_pend` clears on entry to FADE_OUT.
- Fade-step counter `fcnt` (8 b): cleared on every state entry. On each tick in a fade state it increments. When it reaches FADE_FRAMES-1, it wraps and applies one fade step.
- FSM (state changes only on ticks with `hold`=0; with `hold`=1 `scene`, `scene_frame`, `fade`, `fcnt`, state are frozen; `skip_pend` may still latch):
  - FADE_IN: each fade step does `fade`+=1. When `fade` becomes 3 → RUN.
  - RUN: `fade`=3. On a tick with `scene_frame`==SCENE_FRAMES-1 or `skip_pend`=1 → FADE_OUT.
  - FADE_OUT: each fade step does `fade`-=1. On the step that makes `fade` 0, all of the following happen on the same edge:
    - `scene` advances with wrap.
    - `scene_frame` ← 0.
    - `new_scene` pulses.
    - state → FADE_IN.
- `scene_frame`: +1 per unheld tick in all states, saturating at 255. Set to 0 only on scene change; the update on that edge is 0, not 1.
- Simultaneous timeout and skip in RUN: a single FADE_OUT entry, and `skip_pend` clears.

## Timing
- All outputs are registered. Tick-driven updates take effect on the clock edge that first samples `v_sync` low with `vs_q`=1, and are visible the following cycle.
- `new_scene` and `beat` are high for exactly one `clk` cycle.
- Reset values (with fade):
  - `scene`=0, `scene_frame`=0, `fade`=0, state FADE_IN.
  - `fcnt`=0, `bdiv`=0, `beat_step`=0.
  - `beat`=0, `new_scene`=0, `skip_pend`=0, `skip_q`=0.
- Reset values (without fade): the same, except `fade`=3 and state RUN.
- Reset mid-fade or mid-scene returns to these values on the next edge; no pulse is emitted on the reset edge.
- Scene period with fade: SCENE_FRAMES ticks in the scene, followed by 3×FADE_FRAMES ticks of fade-out.

## Configuration
- `DEMO_SEQ_FADE_EN` defined: full FADE_IN/RUN/FADE_OUT behaviour as above.
- Not defined:
  - FSM is RUN only, and `fade` is constant 3; `fcnt` is removed.
  - Timeout or `skip_pend` on an unheld tick immediately advances `scene`, zeroes `scene_frame`, pulses `new_scene`, and clears `skip_pend`.

## Test plan
- Reset with `v_sync` held low, then release → no tick; all outputs hold reset values until the first high→low `v_sync` edge.
- FADE_EN, defaults, 12 ticks → `fade` reads 1 after tick 4, 2 after tick 8, 3 after tick 12, state RUN, `scene_frame`=12.
- FADE_EN, defaults, run to tick 240 since scene entry, then 12 more ticks → `fade` steps 3→2→1→0. `new_scene` pulses once, `scene`=1, `scene_frame`=0, and `fade` begins rising.
- `skip` rising edge in RUN at `scene_frame`=50 → FADE_OUT on the next tick. A second `skip` edge during FADE_OUT produces no extra scene change.
- `hold`=1 for 100 ticks in RUN → `scene`/`scene_frame`/`fade` unchanged, while `beat` pulses 6 or 7 times and `beat_step` keeps advancing. After 240 ticks total, `beat_step` wraps to 0.
- Without `DEMO_SEQ_FADE_EN`, NUM_SCENES=2 → `fade`=3 always. Scene toggles 0→1→0 every 240 ticks with a one-cycle `new_scene` each time.
